// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: load-use/RAW stall detection, multi-cycle redirect flush sequencing
// and data-memory freeze, tracking in-flight destinations in a two-slot EX/MEM scoreboard.
module pipeline_hazard_unit #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int FORWARDING   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  ex_redirect,
   input  logic                  dmem_busy,
   output logic                  stall,
   output logic                  flush,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  freeze,
   output logic [15:0]           bubble_count
);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic {RUN, REDIRECT} state_t;

   state_t                  state, state_n;
   logic [FW-1:0]           fcnt, fcnt_n;
   logic                    ex_v, ex_rw, ex_mr, mem_v, mem_rw;
   logic [REG_ADDR_W-1:0]   ex_rd, mem_rd;
   logic                    match_ex, match_mem, haz_fwd, haz_raw, haz;

   assign match_ex  = (id_uses_rs1 && id_rs1 == ex_rd)  || (id_uses_rs2 && id_rs2 == ex_rd);
   assign match_mem = (id_uses_rs1 && id_rs1 == mem_rd) || (id_uses_rs2 && id_rs2 == mem_rd);
   assign haz_fwd   = ex_v && ex_mr && ex_rd != '0 && match_ex;
   assign haz_raw   = (ex_v && ex_rw && ex_rd != '0 && match_ex) ||
                      (mem_v && mem_rw && mem_rd != '0 && match_mem);
   assign haz       = id_valid && (FORWARDING != 0 ? haz_fwd : haz_raw);

   assign freeze      = dmem_busy;
   assign flush       = !freeze && ((state == RUN && ex_redirect) || state == REDIRECT);
   assign stall       = !freeze && !flush && haz;
   assign pc_write    = !freeze && !stall;
   assign if_id_write = pc_write;

   // ex_redirect is ignored in REDIRECT: EX then holds a wrong-path instruction or a bubble
   always_comb begin
      state_n = state;
      fcnt_n  = fcnt;
      if (!freeze) begin
         if (state == RUN) begin
            if (ex_redirect && FLUSH_CYCLES > 1) begin
               state_n = REDIRECT;
               fcnt_n  = FW'(FLUSH_CYCLES - 1);
            end
         end else begin
            fcnt_n  = fcnt - 1'b1;
            state_n = (fcnt == FW'(1)) ? RUN : REDIRECT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         fcnt         <= '0;
         ex_v         <= 1'b0;
         ex_rd        <= '0;
         ex_rw        <= 1'b0;
         ex_mr        <= 1'b0;
         mem_v        <= 1'b0;
         mem_rd       <= '0;
         mem_rw       <= 1'b0;
         bubble_count <= '0;
      end else begin
         state <= state_n;
         fcnt  <= fcnt_n;
         if (!freeze) begin
            ex_v   <= id_valid && !stall && !flush;
            ex_rd  <= id_rd;
            ex_rw  <= id_reg_write;
            ex_mr  <= id_mem_read;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            mem_rw <= ex_rw;
         end
         if ((stall || flush) && bubble_count != 16'hFFFF)
            bubble_count <= bubble_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: table-driven cycle vectors for the forwarding build, plus hand
// sequences for async reset, the no-forwarding RAW stall and bubble_count saturation.
module tb_pipeline_hazard_unit;
   logic       clk = 1'b0, rst = 1'b1;
   logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, ex_redirect, dmem_busy;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       stall, flush, pc_write, if_id_write, freeze;
   logic       stall_b, flush_b, pc_write_b, if_id_write_b, freeze_b;
   logic [15:0] bubble_count, bubble_count_b;
   int         checks = 0, fails = 0;

   always #5 clk = ~clk;

   pipeline_hazard_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
      .dmem_busy(dmem_busy), .stall(stall), .flush(flush), .pc_write(pc_write),
      .if_id_write(if_id_write), .freeze(freeze), .bubble_count(bubble_count));

   pipeline_hazard_unit #(.FORWARDING(0)) dut_nf (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
      .dmem_busy(dmem_busy), .stall(stall_b), .flush(flush_b), .pc_write(pc_write_b),
      .if_id_write(if_id_write_b), .freeze(freeze_b), .bubble_count(bubble_count_b));

   typedef struct {
      logic       val, u1, u2, rw, mr, redir, busy;
      logic [4:0] rs1, rs2, rd;
      logic       s, f, fz;
      logic [15:0] bc;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic val, input int rs1, rs2, input logic u1, u2,
                               input int rd, input logic rw, mr, redir, busy, s, f, fz, input int bc);
      vec_t v;
      v.val = val; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.rd = 5'(rd);
      v.rw = rw; v.mr = mr; v.redir = redir; v.busy = busy;
      v.s = s; v.f = f; v.fz = fz; v.bc = 16'(bc);
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.val; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
      id_rd = v.rd; id_reg_write = v.rw; id_mem_read = v.mr; ex_redirect = v.redir; dmem_busy = v.busy;
   endtask

   task automatic idle();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      // val rs1 rs2 u1 u2 rd rw mr redir busy | stall flush freeze bc
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tv.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 0, 0, 0));
      tv.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0,  1, 0, 0, 0));
      tv.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0,  0, 0, 0, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 2));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3));
      for (int i = 0; i < 3; i++)
         tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 3));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 3));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 4));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 5));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 5));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 6));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 6));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 7));
      tv.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0,  0, 0, 0, 7));
      tv.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 1, 0,  0, 1, 0, 7));
      tv.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 8));
      tv.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 9));
      tv.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 9));
      tv.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 9));
      tv.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0,  0, 0, 0, 9));
      tv.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 1, 9));
      tv.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 9));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 10));
      tv.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0,  0, 0, 0, 10));
      tv.push_back(mk(1, 0, 9, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 10));

      idle();
      dmem_busy = 1'b1;
      #2;
      chk("rst_freeze_busy", {15'd0, freeze}, 16'd1);
      chk("rst_pcw_busy", {15'd0, pc_write}, 16'd0);
      dmem_busy = 1'b0;
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("rst_stall", {15'd0, stall}, 16'd0);
         chk("rst_flush", {15'd0, flush}, 16'd0);
         chk("rst_pcw", {15'd0, pc_write}, 16'd1);
         chk("rst_bc", bubble_count, 16'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      foreach (tv[i]) begin
         @(negedge clk);
         drive(tv[i]);
         #1;
         chk($sformatf("v%0d_stall", i), {15'd0, stall}, {15'd0, tv[i].s});
         chk($sformatf("v%0d_flush", i), {15'd0, flush}, {15'd0, tv[i].f});
         chk($sformatf("v%0d_freeze", i), {15'd0, freeze}, {15'd0, tv[i].fz});
         chk($sformatf("v%0d_pcw", i), {15'd0, pc_write}, {15'd0, !tv[i].fz && !tv[i].s});
         chk($sformatf("v%0d_ifid", i), {15'd0, if_id_write}, {15'd0, !tv[i].fz && !tv[i].s});
         chk($sformatf("v%0d_bc", i), bubble_count, tv[i].bc);
      end

      // async reset while in REDIRECT
      @(negedge clk);
      idle();
      ex_redirect = 1'b1;
      @(negedge clk);
      ex_redirect = 1'b0;
      #1;
      chk("redir_pre_rst_flush", {15'd0, flush}, 16'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_flush", {15'd0, flush}, 16'd0);
      chk("async_rst_bc", bubble_count, 16'd0);
      chk("async_rst_pcw", {15'd0, pc_write}, 16'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_flush", {15'd0, flush}, 16'd0);

      // no-forwarding RAW: producer in EX then MEM gives two stall cycles
      @(negedge clk);
      drive(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0));
      #1;
      chk("nf_add_stall", {15'd0, stall_b}, 16'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(mk(1, 1, 3, 1, 1, 4, 1, 0, 0, 0,  0, 0, 0, 0));
         #1;
         chk($sformatf("nf_use%0d_stall", i), {15'd0, stall_b}, {15'd0, i < 2});
         chk($sformatf("nf_use%0d_pcw", i), {15'd0, pc_write_b}, {15'd0, i >= 2});
         if (i == 0) chk("fwd_alu_nostall", {15'd0, stall}, 16'd0);
      end
      chk("nf_bc", bubble_count_b, 16'd2);

      // saturation under continuous flush
      @(negedge clk);
      rst = 1'b1;
      idle();
      @(negedge clk);
      rst = 1'b0;
      ex_redirect = 1'b1;
      repeat (65534) @(negedge clk);
      #1;
      chk("sat_fffe", bubble_count, 16'hFFFE);
      chk("sat_flush", {15'd0, flush}, 16'd1);
      repeat (5) @(negedge clk);
      #1;
      chk("sat_ffff", bubble_count, 16'hFFFF);
      ex_redirect = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
